// File: rtl/noc_sequencer_pkg.sv
// Shared constants, op codes and FSM state encoding for the NoC phase sequencer.
package noc_sequencer_pkg;

  localparam int unsigned MaxRouter   = 16;
  localparam int unsigned OpSize      = 3;
  localparam int unsigned DataSize    = 32;
  localparam int unsigned InCycleSize = 16;

  typedef enum logic [2:0] {
    OpNop         = 3'd0,
    OpInit        = 3'd1,
    OpLoadRt      = 3'd2,
    OpLoadStaging = 3'd3,
    OpPhase0      = 3'd4,
    OpPhase1      = 3'd5,
    OpCopyStaging = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLoadRt,
    StLoad,
    StPh0,
    StPh1,
    StCopy,
    StFin
  } state_e;

endpackage

// File: rtl/noc_sequencer.sv
// Global phase sequencer: initialises the router array, streams routing-table words,
// then steps LoadStaging/Phase0/Phase1/CopyStaging per simulated cycle until done or budget.
module noc_sequencer
  import noc_sequencer_pkg::*;
#(
  parameter int unsigned MAX_ROUTER    = MaxRouter,
  parameter int unsigned OP_SIZE       = OpSize,
  parameter int unsigned DATA_SIZE     = DataSize,
  parameter int unsigned IN_CYCLE_SIZE = InCycleSize
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IN_CYCLE_SIZE-1:0] num_cycles,
  input  logic                     rt_valid,
  input  logic [DATA_SIZE-1:0]     rt_data,
  input  logic                     rt_last,
  output logic                     rt_ready,
  input  logic [MAX_ROUTER-1:0]    router_done,
  output logic [OP_SIZE-1:0]       op,
  output logic [DATA_SIZE-1:0]     data,
  output logic [IN_CYCLE_SIZE-1:0] in_cycle,
  output logic                     busy,
  output logic                     finished,
  output logic                     early
);

  function automatic logic [OP_SIZE-1:0] opw(input op_e o);
    return OP_SIZE'(o);
  endfunction

  state_e                   state_q;
  logic                     last_q;
  logic [IN_CYCLE_SIZE-1:0] budget_q;
  logic [OP_SIZE-1:0]       op_q;
  logic [DATA_SIZE-1:0]     data_q;
  logic [IN_CYCLE_SIZE-1:0] in_cycle_q;
  logic                     rt_ready_q;
  logic                     busy_q;
  logic                     finished_q;
  logic                     early_q;

  logic                     rt_hs;
  logic                     all_done;
  logic [IN_CYCLE_SIZE-1:0] cycle_inc;

  assign rt_hs     = rt_valid & rt_ready_q;
  assign all_done  = &router_done;
  assign cycle_inc = in_cycle_q + IN_CYCLE_SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b0;
      budget_q   <= '0;
      op_q       <= opw(OpNop);
      data_q     <= '0;
      in_cycle_q <= '0;
      rt_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          op_q <= opw(OpNop);
          if (start) begin
            budget_q   <= num_cycles;
            busy_q     <= 1'b1;
            in_cycle_q <= '0;
            early_q    <= 1'b0;
            op_q       <= opw(OpInit);
            state_q    <= StInit;
          end
        end
        StInit: begin
          op_q       <= opw(OpNop);
          rt_ready_q <= 1'b1;
          last_q     <= 1'b0;
          state_q    <= StLoadRt;
        end
        StLoadRt: begin
          // last_q marks the drain clock that presents the final word before leaving.
          if (last_q) begin
            last_q <= 1'b0;
            if (budget_q == '0) begin
              op_q       <= opw(OpNop);
              finished_q <= 1'b1;
              early_q    <= 1'b0;
              state_q    <= StFin;
            end else begin
              op_q    <= opw(OpLoadStaging);
              state_q <= StLoad;
            end
          end else if (rt_hs) begin
            op_q   <= opw(OpLoadRt);
            data_q <= rt_data;
            if (rt_last) begin
              last_q     <= 1'b1;
              rt_ready_q <= 1'b0;
            end
          end else begin
            op_q <= opw(OpNop);
          end
        end
        StLoad: begin
          op_q    <= opw(OpPhase0);
          state_q <= StPh0;
        end
        StPh0: begin
          op_q    <= opw(OpPhase1);
          state_q <= StPh1;
        end
        StPh1: begin
          op_q    <= opw(OpCopyStaging);
          state_q <= StCopy;
        end
        StCopy: begin
          in_cycle_q <= cycle_inc;
          if (all_done || (cycle_inc == budget_q)) begin
            op_q       <= opw(OpNop);
            finished_q <= 1'b1;
            early_q    <= all_done;
            state_q    <= StFin;
          end else begin
            op_q    <= opw(OpLoadStaging);
            state_q <= StLoad;
          end
        end
        StFin: begin
          op_q       <= opw(OpNop);
          finished_q <= 1'b0;
          early_q    <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op       = op_q;
  assign data     = data_q;
  assign in_cycle = in_cycle_q;
  assign rt_ready = rt_ready_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign early    = early_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// Randomised scoreboard bench for noc_sequencer: per-run expected traces are queued up front
// and a free-running monitor compares every busy clock against them.
module tb_noc_sequencer;

  localparam int MR = 16;
  localparam int OS = 3;
  localparam int DS = 32;
  localparam int CS = 16;

  localparam logic [2:0] NOP = 3'd0, INIT = 3'd1, LRT = 3'd2, LST = 3'd3;
  localparam logic [2:0] PH0 = 3'd4, PH1 = 3'd5, CPY = 3'd6;

  typedef struct packed {
    logic [2:0]    op;
    logic [DS-1:0] data;
    logic [CS-1:0] cyc;
    logic          ready;
    logic          fin;
    logic          early;
  } exp_t;

  typedef struct packed {
    logic          start;
    logic          rv;
    logic [DS-1:0] rd;
    logic          rl;
    logic [MR-1:0] done;
  } stim_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CS-1:0] num_cycles;
  logic          rt_valid;
  logic [DS-1:0] rt_data;
  logic          rt_last;
  logic          rt_ready;
  logic [MR-1:0] router_done;
  logic [OS-1:0] op;
  logic [DS-1:0] data;
  logic [CS-1:0] in_cycle;
  logic          busy;
  logic          finished;
  logic          early;

  noc_sequencer #(
    .MAX_ROUTER   (MR),
    .OP_SIZE      (OS),
    .DATA_SIZE    (DS),
    .IN_CYCLE_SIZE(CS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .rt_valid   (rt_valid),
    .rt_data    (rt_data),
    .rt_last    (rt_last),
    .rt_ready   (rt_ready),
    .router_done(router_done),
    .op         (op),
    .data       (data),
    .in_cycle   (in_cycle),
    .busy       (busy),
    .finished   (finished),
    .early      (early)
  );

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DS-1:0] m_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] o, input logic [DS-1:0] d, input int c,
                              input logic rdy, input logic f, input logic e);
    exp_t x;
    x.op    = o;
    x.data  = d;
    x.cyc   = CS'(c);
    x.ready = rdy;
    x.fin   = f;
    x.early = e;
    return x;
  endfunction

  // kind 0: any done value; 1: COPY clock that must not end the run; 2: all routers done
  function automatic stim_t noise(input int kind);
    stim_t s;
    s.start = 1'($urandom_range(0, 1));
    s.rv    = 1'($urandom_range(0, 1));
    s.rd    = $urandom;
    s.rl    = 1'($urandom_range(0, 1));
    case (kind)
      1: begin
        s.done = MR'($urandom);
        s.done[$urandom_range(0, MR-1)] = 1'b0;
      end
      2:       s.done = '1;
      default: s.done = ($urandom_range(0, 2) == 0) ? '1 : MR'($urandom);
    endcase
    return s;
  endfunction

  // Monitor: every clock with busy high must match the next queued expectation.
  initial begin
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && busy) begin
        a.op    = op;
        a.data  = data;
        a.cyc   = in_cycle;
        a.ready = rt_ready;
        a.fin   = finished;
        a.early = early;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected busy clock: got %0h, expected no activity", a);
        end else begin
          check("trace", 64'(a), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // vmode 0: no stalls, 1: random gaps, 2: fixed 1,0,0,1 pattern (two words)
  task automatic run_seq(input int budget, input int nwords, input int done_cyc,
                         input int vmode, input bit abort);
    stim_t         st[$];
    exp_t          ex[$];
    bit            vpat[$];
    logic [DS-1:0] words[$];
    logic [DS-1:0] d;
    stim_t         s;
    int            wi;
    int            abort_idx;
    abort_idx = -1;
    for (int w = 0; w < nwords; w++) words.push_back($urandom);
    if (vmode == 2) begin
      vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    end else begin
      for (int w = 0; w < nwords; w++) begin
        if (vmode == 1) repeat ($urandom_range(0, 2)) vpat.push_back(1'b0);
        vpat.push_back(1'b1);
      end
    end
    d = m_data;
    st.push_back(noise(0));
    ex.push_back(mk(INIT, d, 0, 1'b0, 1'b0, 1'b0));
    wi = 0;
    for (int j = 0; j < vpat.size(); j++) begin
      s    = noise(0);
      s.rv = vpat[j];
      if (vpat[j]) begin
        s.rd = words[wi];
        s.rl = (wi == nwords - 1);
      end
      st.push_back(s);
      ex.push_back(mk((j > 0 && vpat[j-1]) ? LRT : NOP, d, 0, 1'b1, 1'b0, 1'b0));
      if (vpat[j]) begin
        d = words[wi];
        wi++;
      end
    end
    st.push_back(noise(0));
    ex.push_back(mk(LRT, d, 0, 1'b0, 1'b0, 1'b0));
    if (budget == 0) begin
      st.push_back(noise(0));
      ex.push_back(mk(NOP, d, 0, 1'b0, 1'b1, 1'b0));
    end else begin
      for (int c = 0; ; c++) begin
        st.push_back(noise(0));
        ex.push_back(mk(LST, d, c, 1'b0, 1'b0, 1'b0));
        if (abort && c == 3) abort_idx = ex.size();
        st.push_back(noise(0));
        ex.push_back(mk(PH0, d, c, 1'b0, 1'b0, 1'b0));
        st.push_back(noise(0));
        ex.push_back(mk(PH1, d, c, 1'b0, 1'b0, 1'b0));
        st.push_back(noise(c == done_cyc ? 2 : 1));
        ex.push_back(mk(CPY, d, c, 1'b0, 1'b0, 1'b0));
        if (c == done_cyc || c + 1 == budget) begin
          st.push_back(noise(0));
          ex.push_back(mk(NOP, d, c + 1, 1'b0, 1'b1, (c == done_cyc)));
          break;
        end
      end
    end
    foreach (ex[k]) exp_q.push_back(ex[k]);

    @(negedge clk);
    start      = 1'b1;
    num_cycles = CS'(budget);
    rt_valid   = 1'b0;
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (i == abort_idx) begin
        rst      = 1'b1;
        start    = 1'b0;
        rt_valid = 1'b0;
        break;
      end
      start       = st[i].start;
      num_cycles  = CS'($urandom);
      rt_valid    = st[i].rv;
      rt_data     = st[i].rd;
      rt_last     = st[i].rl;
      router_done = st[i].done;
    end

    if (abort) begin
      @(negedge clk);
      check("abort op", 64'(op), 64'(NOP));
      check("abort in_cycle", 64'(in_cycle), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort rt_ready", 64'(rt_ready), 64'd0);
      check("abort data", 64'(data), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      m_data = '0;
    end else begin
      m_data = d;
      @(negedge clk);
      start    = 1'b0;
      rt_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("queue drained", 64'(exp_q.size()), 64'd0);
      check("idle after run", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int b;
    rst         = 1'b1;
    start       = 1'b1;
    num_cycles  = '0;
    rt_valid    = 1'b1;
    rt_data     = '0;
    rt_last     = 1'b0;
    router_done = '0;
    repeat (3) @(negedge clk);
    check("reset op", 64'(op), 64'(NOP));
    check("reset data", 64'(data), 64'd0);
    check("reset in_cycle", 64'(in_cycle), 64'd0);
    check("reset rt_ready", 64'(rt_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset finished", 64'(finished), 64'd0);
    check("reset early", 64'(early), 64'd0);
    rst      = 1'b0;
    start    = 1'b0;
    rt_valid = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(3, 2, -1, 0, 1'b0);
    run_seq(4, 2, -1, 2, 1'b0);
    run_seq(10, 3, 4, 1, 1'b0);
    run_seq(0, 2, -1, 1, 1'b0);
    run_seq(10, 2, -1, 0, 1'b1);
    run_seq(2, 1, -1, 0, 1'b0);
    run_seq(3, 1, 2, 0, 1'b0);
    repeat (25) begin
      b = $urandom_range(1, 8);
      run_seq(b, $urandom_range(1, 5),
              ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, b - 1),
              $urandom_range(0, 1), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
